// File: rtl/motor_speed_ramp_if.sv
// Command channel into the speed ramp: signed left/right targets with a valid/ready handshake.
// The master drives commands and the slave (the ramp block) returns ready.
interface motor_speed_ramp_if;
    logic signed [7:0] cmd_left_in;
    logic signed [7:0] cmd_right_in;
    logic              cmd_valid_in;
    logic              cmd_ready_out;

    modport master (
        output cmd_left_in,
        output cmd_right_in,
        output cmd_valid_in,
        input  cmd_ready_out
    );

    modport slave (
        input  cmd_left_in,
        input  cmd_right_in,
        input  cmd_valid_in,
        output cmd_ready_out
    );
endinterface

// File: rtl/motor_speed_ramp.sv
// Slew-rate limiter in front of the PWM driver.
// It also provides a command watchdog that ramps the outputs to zero and an emergency stop that zeroes them at once.
module motor_speed_ramp #(
    parameter int TICK_CYCLES   = 98304,
    parameter int STEP          = 4,
    parameter int TIMEOUT_TICKS = 250
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    motor_speed_ramp_if.slave   cmd_if,
    input  logic                estop_in,
    output logic signed [7:0]   speed_left,
    output logic signed [7:0]   speed_right,
    output logic                ramping_out,
    output logic                timeout_out
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int WW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0]     TICK_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [WW-1:0]     WD_LIMIT  = WW'(TIMEOUT_TICKS);
    localparam logic signed [8:0] STEP_S    = 9'(STEP);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_TIMEOUT,
        ST_ESTOP
    } state_t;

    // -128 has no positive mirror, so it is pulled in to keep the range symmetric.
    function automatic logic signed [7:0] clamp_cmd(input logic signed [7:0] v);
        return (v == -8'sd128) ? -8'sd127 : v;
    endfunction

    // One slew step toward tgt; 9-bit difference so +127 -> -127 cannot wrap.
    function automatic logic signed [7:0] ramp_step(input logic signed [7:0] spd,
                                                    input logic signed [7:0] tgt);
        logic signed [8:0] s9;
        logic signed [8:0] t9;
        logic signed [8:0] diff;
        s9   = {spd[7], spd};
        t9   = {tgt[7], tgt};
        diff = t9 - s9;
        if (diff <= STEP_S && diff >= -STEP_S)
            return tgt;
        else if (diff > 9'sd0)
            return 8'(s9 + STEP_S);
        else
            return 8'(s9 - STEP_S);
    endfunction

    state_t            r_state;
    logic [CW-1:0]     r_tick_cnt;
    logic [WW-1:0]     r_wd_cnt;
    logic signed [7:0] r_tgt_left;
    logic signed [7:0] r_tgt_right;
    logic signed [7:0] r_speed_left;
    logic signed [7:0] r_speed_right;
    logic              r_cmd_ready;
    logic              r_timeout;

    logic              w_tick;
    logic              w_accept;
    logic              w_expire;
    logic [WW-1:0]     w_wd_next;
    logic signed [7:0] w_tgt_left;
    logic signed [7:0] w_tgt_right;

    assign w_tick    = (r_tick_cnt == TICK_LAST);
    // Estop overrides a handshake that would otherwise complete on the same edge.
    assign w_accept  = cmd_if.cmd_valid_in & r_cmd_ready & ~estop_in;
    assign w_wd_next = (r_wd_cnt == WD_LIMIT) ? r_wd_cnt : r_wd_cnt + 1'b1;
    assign w_expire  = w_tick & (r_state == ST_RUN) & ~w_accept & (w_wd_next == WD_LIMIT);

    // A command accepted on a tick edge is already the target for that tick.
    assign w_tgt_left  = w_accept ? clamp_cmd(cmd_if.cmd_left_in)  : r_tgt_left;
    assign w_tgt_right = w_accept ? clamp_cmd(cmd_if.cmd_right_in) : r_tgt_right;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tick_cnt <= '0;
        end else begin
            // NOTE: registers use non-blocking assignment so every block samples pre-edge values.
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= ST_RUN;
            r_wd_cnt      <= '0;
            r_tgt_left    <= '0;
            r_tgt_right   <= '0;
            r_speed_left  <= '0;
            r_speed_right <= '0;
            r_cmd_ready   <= 1'b0;
            r_timeout     <= 1'b0;
        end else if (estop_in) begin
            r_state       <= ST_ESTOP;
            r_wd_cnt      <= '0;
            r_tgt_left    <= '0;
            r_tgt_right   <= '0;
            r_speed_left  <= '0;
            r_speed_right <= '0;
            r_cmd_ready   <= 1'b0;
            r_timeout     <= 1'b0;
        end else if (r_state == ST_ESTOP) begin
            r_state     <= ST_RUN;
            r_wd_cnt    <= '0;
            r_timeout   <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_cmd_ready <= 1'b1;
            if (w_tick) begin
                r_speed_left  <= ramp_step(r_speed_left,  w_tgt_left);
                r_speed_right <= ramp_step(r_speed_right, w_tgt_right);
            end
            if (w_accept) begin
                r_state     <= ST_RUN;
                r_tgt_left  <= w_tgt_left;
                r_tgt_right <= w_tgt_right;
                r_wd_cnt    <= '0;
                r_timeout   <= 1'b0;
            end else if (w_expire) begin
                r_state     <= ST_TIMEOUT;
                r_tgt_left  <= '0;
                r_tgt_right <= '0;
                r_wd_cnt    <= w_wd_next;
                r_timeout   <= 1'b1;
            end else if (w_tick && r_state == ST_RUN) begin
                r_wd_cnt <= w_wd_next;
            end
        end
    end

    assign cmd_if.cmd_ready_out = r_cmd_ready;
    assign speed_left           = r_speed_left;
    assign speed_right          = r_speed_right;
    assign timeout_out          = r_timeout;
    assign ramping_out          = (r_speed_left != r_tgt_left) | (r_speed_right != r_tgt_right);

endmodule
